usb_ep0_sequencer: RTL and testbench

Control-transfer sequencer for endpoint 0. It sits between the `usb` protocol core and the setup-packet decoder. It tracks the SETUP / DATA / STATUS stages and owns the DATA0/DATA1 toggle. It chooses the handshake for every token, budgets IN payload bytes, and commits the device address after a SET_ADDRESS status stage.

---
 rtl/usb_pkg.sv | 30 +++
 rtl/usb_txn_edge.sv | 49 ++++
 rtl/usb_ep0_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_usb_ep0_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared constants for the EP0 control-transfer sequencer: handshake codes,
// stage encodings, and the EP0 endpoint number.
package usb_pkg;

   localparam logic [1:0] hs_ack   = 2'b00;
   localparam logic [1:0] hs_none  = 2'b01;
   localparam logic [1:0] hs_nak   = 2'b10;
   localparam logic [1:0] hs_stall = 2'b11;

   localparam logic [3:0] EP0 = 4'd0;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DECODE     = 3'd1,
      ST_DATA_IN    = 3'd2,
      ST_DATA_OUT   = 3'd3,
      ST_STATUS_IN  = 3'd4,
      ST_STATUS_OUT = 3'd5,
      ST_STALLED    = 3'd6
   } stage_e;

   function automatic logic [6:0] min_budget(input logic [15:0] rem, input logic [6:0] max_pkt);
      if (rem < {9'd0, max_pkt}) begin
         return rem[6:0];
      end else begin
         return max_pkt;
      end
   endfunction

endpackage

// File: rtl/usb_txn_edge.sv
// Registers transaction_active, derives start/end pulses and holds the token
// fields captured at the start of each transaction.
module usb_txn_edge
   import usb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       active_i,
   input  logic [3:0] endpoint_i,
   input  logic       dir_in_i,
   input  logic       setup_i,
   output logic       start_o,
   output logic       end_o,
   output logic       active_o,
   output logic [3:0] endpoint_o,
   output logic       dir_in_o,
   output logic       setup_o
);

   logic       act_q;
   logic [3:0] ep_q;
   logic       dir_q;
   logic       setup_q;

   assign start_o    = active_i & ~act_q;
   assign end_o      = ~active_i & act_q;
   assign active_o   = act_q;
   assign endpoint_o = ep_q;
   assign dir_in_o   = dir_q;
   assign setup_o    = setup_q;

   // Activity register and token-field capture on the start edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         act_q   <= 1'b0;
         ep_q    <= 4'd0;
         dir_q   <= 1'b0;
         setup_q <= 1'b0;
      end else begin
         act_q <= active_i;
         if (start_o) begin
            ep_q    <= endpoint_i;
            dir_q   <= dir_in_i;
            setup_q <= setup_i;
         end
      end
   end

endmodule

// File: rtl/usb_ep0_sequencer.sv
// EP0 control-transfer sequencer: stage tracking, DATA0/DATA1 toggle,
// handshake selection, IN byte budgeting and deferred address commit.
module usb_ep0_sequencer
   import usb_pkg::*;
#(
   parameter int MAX_PKT = 8
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        usb_rst,
   input  logic        transaction_active,
   input  logic [3:0]  endpoint,
   input  logic        direction_in,
   input  logic        setup,
   input  logic        success,
   input  logic        data_strobe,
   input  logic        req_valid,
   input  logic        req_dir_in,
   input  logic [15:0] req_len,
   input  logic        req_stall,
   input  logic        req_set_addr,
   input  logic [6:0]  req_addr,
   output logic [1:0]  handshake,
   output logic        data_toggle,
   output logic [6:0]  usb_address,
   output logic [6:0]  in_budget,
   output logic [2:0]  stage,
   output logic        xfer_done
);

   localparam logic [6:0] MAX7 = 7'(MAX_PKT);

   stage_e      state_q, state_d;
   logic [15:0] rem_q, rem_d;
   logic        tog_q, tog_d;
   logic [6:0]  addr_q, addr_d;
   logic [6:0]  pend_q, pend_d;
   logic        pend_v_q, pend_v_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [1:0]  hs_q, hs_d;
   logic        dtog_q, dtog_d;
   logic [6:0]  bud_q, bud_d;
   logic        done_q, done_d;

   logic        rst_s, start_s, end_s, act_s, din_s, stp_s, setup_start_s, last_s;
   logic [3:0]  ep_s;
   logic [15:0] rem_sub_s;

   assign rst_s = rst | usb_rst;

   usb_txn_edge u_edge (
      .clk_i      (clk),
      .rst_i      (rst_s),
      .active_i   (transaction_active),
      .endpoint_i (endpoint),
      .dir_in_i   (direction_in),
      .setup_i    (setup),
      .start_o    (start_s),
      .end_o      (end_s),
      .active_o   (act_s),
      .endpoint_o (ep_s),
      .dir_in_o   (din_s),
      .setup_o    (stp_s)
   );

   // Remaining count never underflows; a packet shorter than MAX_PKT also ends the data stage.
   assign setup_start_s = start_s & setup & (endpoint == EP0);
   assign rem_sub_s     = (rem_q > {9'd0, cnt_q}) ? (rem_q - {9'd0, cnt_q}) : 16'd0;
   assign last_s        = (rem_sub_s == 16'd0) || (cnt_q < MAX7);

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      tog_d    = tog_q;
      addr_d   = addr_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      cnt_d    = cnt_q;
      hs_d     = hs_q;
      dtog_d   = dtog_q;
      bud_d    = bud_q;
      done_d   = 1'b0;

      if (start_s) begin
         cnt_d = 7'd0;
      end else if (act_s && data_strobe && (cnt_q != 7'h7f)) begin
         cnt_d = cnt_q + 7'd1;
      end else begin
         cnt_d = cnt_q;
      end

      if (act_s) begin
         hs_d   = hs_stall;
         bud_d  = 7'd0;
         dtog_d = tog_q;
         if (ep_s != EP0) begin
            hs_d = hs_stall;
         end else if (stp_s) begin
            hs_d   = hs_ack;
            dtog_d = 1'b0;
         end else begin
            case (state_q)
               ST_DECODE:     hs_d = hs_nak;
               ST_DATA_IN: begin
                  hs_d   = hs_ack;
                  bud_d  = din_s ? min_budget(rem_q, MAX7) : 7'd0;
                  dtog_d = din_s ? tog_q : 1'b1;
               end
               ST_DATA_OUT:   hs_d = din_s ? hs_nak : hs_ack;
               ST_STATUS_IN: begin
                  hs_d   = din_s ? hs_ack : hs_nak;
                  dtog_d = 1'b1;
               end
               ST_STATUS_OUT: begin
                  hs_d   = din_s ? hs_nak : hs_ack;
                  dtog_d = 1'b1;
               end
               default:       hs_d = hs_stall;
            endcase
         end
      end else begin
         hs_d = hs_q;
      end

      if (setup_start_s) begin
         state_d  = ST_IDLE;
         tog_d    = 1'b0;
         pend_v_d = 1'b0;
      end else if (req_valid && (state_q == ST_DECODE)) begin
         if (req_stall) begin
            state_d = ST_STALLED;
         end else begin
            rem_d = req_len;
            tog_d = 1'b1;
            if (req_set_addr) begin
               pend_d   = req_addr;
               pend_v_d = 1'b1;
            end else begin
               pend_v_d = pend_v_q;
            end
            if (req_len == 16'd0) begin
               state_d = ST_STATUS_IN;
            end else begin
               state_d = req_dir_in ? ST_DATA_IN : ST_DATA_OUT;
            end
         end
      end else if (end_s && (ep_s == EP0)) begin
         if (stp_s) begin
            state_d = success ? ST_DECODE : ST_IDLE;
         end else if (success) begin
            case (state_q)
               ST_DATA_IN: begin
                  if (din_s) begin
                     rem_d   = rem_sub_s;
                     tog_d   = ~tog_q;
                     state_d = last_s ? ST_STATUS_OUT : ST_DATA_IN;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
               ST_DATA_OUT: begin
                  if (!din_s) begin
                     rem_d   = rem_sub_s;
                     tog_d   = ~tog_q;
                     state_d = last_s ? ST_STATUS_IN : ST_DATA_OUT;
                  end else begin
                     state_d = state_q;
                  end
               end
               ST_STATUS_IN: begin
                  if (din_s) begin
                     addr_d   = pend_v_q ? pend_q : addr_q;
                     pend_v_d = 1'b0;
                     state_d  = ST_IDLE;
                     done_d   = 1'b1;
                  end else begin
                     state_d = state_q;
                  end
               end
               ST_STATUS_OUT: begin
                  if (!din_s) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = state_q;
                  end
               end
               default: state_d = state_q;
            endcase
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_s) begin
         state_q  <= ST_IDLE;
         rem_q    <= 16'd0;
         tog_q    <= 1'b0;
         addr_q   <= 7'd0;
         pend_q   <= 7'd0;
         pend_v_q <= 1'b0;
         cnt_q    <= 7'd0;
         hs_q     <= hs_nak;
         dtog_q   <= 1'b0;
         bud_q    <= 7'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         tog_q    <= tog_d;
         addr_q   <= addr_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         cnt_q    <= cnt_d;
         hs_q     <= hs_d;
         dtog_q   <= dtog_d;
         bud_q    <= bud_d;
         done_q   <= done_d;
      end
   end

   assign handshake   = hs_q;
   assign data_toggle = dtog_q;
   assign usb_address = addr_q;
   assign in_budget   = bud_q;
   assign stage       = state_q;
   assign xfer_done   = done_q;

endmodule

// File: tb/tb_usb_ep0_sequencer.sv
// Self-checking bench for usb_ep0_sequencer: directed control transfers plus
// randomized transfers against a transfer-level reference model.
module tb_usb_ep0_sequencer;
   import usb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0, usb_rst = 1'b0, transaction_active = 1'b0;
   logic [3:0]  endpoint = 4'd0;
   logic        direction_in = 1'b0, setup = 1'b0, success = 1'b0, data_strobe = 1'b0;
   logic        req_valid = 1'b0, req_dir_in = 1'b0, req_stall = 1'b0, req_set_addr = 1'b0;
   logic [15:0] req_len = 16'd0;
   logic [6:0]  req_addr = 7'd0;
   logic [1:0]  handshake;
   logic        data_toggle, xfer_done;
   logic [6:0]  usb_address, in_budget;
   logic [2:0]  stage;

   usb_ep0_sequencer #(.MAX_PKT(8)) dut (
      .clk(clk), .rst(rst), .usb_rst(usb_rst), .transaction_active(transaction_active),
      .endpoint(endpoint), .direction_in(direction_in), .setup(setup), .success(success),
      .data_strobe(data_strobe), .req_valid(req_valid), .req_dir_in(req_dir_in),
      .req_len(req_len), .req_stall(req_stall), .req_set_addr(req_set_addr),
      .req_addr(req_addr), .handshake(handshake), .data_toggle(data_toggle),
      .usb_address(usb_address), .in_budget(in_budget), .stage(stage), .xfer_done(xfer_done)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model of the control transfer
   logic [2:0] m_st;
   int         m_rem;
   logic       m_tog, m_pv;
   logic [6:0] m_addr, m_pend;

   logic [1:0] exp_hs, obs_hs;
   logic       exp_tog, obs_tog, exp_done, obs_done, obs_done2;
   logic [6:0] exp_bud, obs_bud, exp_addr, obs_addr;
   logic [2:0] exp_st, obs_st;

   task automatic model_reset();
      m_st = ST_IDLE; m_rem = 0; m_tog = 1'b0; m_pv = 1'b0; m_addr = 7'd0; m_pend = 7'd0;
   endtask

   task automatic model_data(input int n, input logic [2:0] nxt);
      m_rem = (m_rem > n) ? m_rem - n : 0;
      m_tog = ~m_tog;
      if (m_rem == 0 || n < 8) m_st = nxt;
   endtask

   task automatic model_token(input logic [3:0] ep, input logic din, input logic stp,
                              input int n, input logic ok);
      exp_done = 1'b0; exp_bud = 7'd0; exp_tog = 1'b0;
      if (ep != 4'd0) begin
         exp_hs = hs_stall;
      end else if (stp) begin
         m_tog = 1'b0; m_pv = 1'b0;
         exp_hs = hs_ack;
         m_st = ok ? ST_DECODE : ST_IDLE;
      end else begin
         case (m_st)
            ST_DECODE: exp_hs = hs_nak;
            ST_DATA_IN: begin
               exp_hs  = hs_ack;
               exp_tog = din ? m_tog : 1'b1;
               exp_bud = din ? 7'((m_rem < 8) ? m_rem : 8) : 7'd0;
               if (ok && din) model_data(n, ST_STATUS_OUT);
               else if (ok) begin m_st = ST_IDLE; exp_done = 1'b1; end
            end
            ST_DATA_OUT: begin
               exp_hs  = din ? hs_nak : hs_ack;
               exp_tog = m_tog;
               if (ok && !din) model_data(n, ST_STATUS_IN);
            end
            ST_STATUS_IN: begin
               exp_hs  = din ? hs_ack : hs_nak;
               exp_tog = 1'b1;
               if (ok && din) begin
                  if (m_pv) m_addr = m_pend;
                  m_pv = 1'b0; m_st = ST_IDLE; exp_done = 1'b1;
               end
            end
            ST_STATUS_OUT: begin
               exp_hs  = din ? hs_nak : hs_ack;
               exp_tog = 1'b1;
               if (ok && !din) begin m_st = ST_IDLE; exp_done = 1'b1; end
            end
            default: exp_hs = hs_stall;
         endcase
      end
      exp_st = m_st; exp_addr = m_addr;
   endtask

   task automatic run_token(input logic [3:0] ep, input logic din, input logic stp,
                            input int n, input logic ok);
      @(negedge clk);
      endpoint = ep; direction_in = din; setup = stp; success = ok; transaction_active = 1'b1;
      repeat (3) @(negedge clk);
      obs_hs = handshake; obs_tog = data_toggle; obs_bud = in_budget;
      for (int i = 0; i < n; i++) begin
         data_strobe = 1'b1;
         @(negedge clk);
      end
      data_strobe = 1'b0; transaction_active = 1'b0;
      @(negedge clk);
      obs_st = stage; obs_done = xfer_done; obs_addr = usb_address;
      @(negedge clk);
      obs_done2 = xfer_done;
   endtask

   task automatic tok(input logic [3:0] ep, input logic din, input logic stp,
                      input int n, input logic ok);
      model_token(ep, din, stp, n, ok);
      run_token(ep, din, stp, n, ok);
   endtask

   task automatic send_req(input logic din, input logic [15:0] len, input logic stl,
                           input logic sa, input logic [6:0] a);
      if (m_st == ST_DECODE) begin
         if (stl) m_st = ST_STALLED;
         else begin
            m_rem = int'(len); m_tog = 1'b1;
            if (sa) begin m_pend = a; m_pv = 1'b1; end
            m_st = (len == 16'd0) ? ST_STATUS_IN : (din ? ST_DATA_IN : ST_DATA_OUT);
         end
      end
      exp_st = m_st;
      @(negedge clk);
      req_dir_in = din; req_len = len; req_stall = stl; req_set_addr = sa; req_addr = a;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      obs_st = stage;
   endtask

   task automatic check_reset_values(input string tag);
      total++; if (handshake !== hs_nak) begin bad++; $display("FAIL %s_hs got=%0d want=%0d", tag, handshake, hs_nak); end
      total++; if (data_toggle !== 1'b0) begin bad++; $display("FAIL %s_tog got=%0d want=0", tag, data_toggle); end
      total++; if (usb_address !== 7'd0) begin bad++; $display("FAIL %s_addr got=%0h want=0", tag, usb_address); end
      total++; if (in_budget !== 7'd0) begin bad++; $display("FAIL %s_bud got=%0d want=0", tag, in_budget); end
      total++; if (stage !== ST_IDLE) begin bad++; $display("FAIL %s_stage got=%0d want=%0d", tag, stage, ST_IDLE); end
      total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL %s_done got=%0d want=0", tag, xfer_done); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_values("reset");
   endtask

   task automatic test_set_address();
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b0, 16'd0, 1'b0, 1'b1, 7'h2A);
      total++; if (obs_st !== ST_STATUS_IN) begin bad++; $display("FAIL setaddr_stage got=%0d want=%0d", obs_st, ST_STATUS_IN); end
      tok(4'd0, 1'b1, 1'b0, 0, 1'b0);
      total++; if (obs_addr !== 7'd0) begin bad++; $display("FAIL setaddr_fail_addr got=%0h want=0", obs_addr); end
      total++; if (obs_done !== 1'b0) begin bad++; $display("FAIL setaddr_fail_done got=%0d want=0", obs_done); end
      tok(4'd0, 1'b1, 1'b0, 0, 1'b1);
      total++; if (obs_hs !== hs_ack || obs_bud !== 7'd0 || obs_tog !== 1'b1) begin
         bad++; $display("FAIL setaddr_status got hs=%0d bud=%0d tog=%0d want hs=0 bud=0 tog=1", obs_hs, obs_bud, obs_tog); end
      total++; if (obs_addr !== 7'h2A) begin bad++; $display("FAIL setaddr_addr got=%0h want=2a", obs_addr); end
      total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL setaddr_done got=%0d want=1", obs_done); end
      total++; if (obs_done2 !== 1'b0) begin bad++; $display("FAIL setaddr_done_pulse got=%0d want=0", obs_done2); end
   endtask

   task automatic test_get_descriptor();
      logic [6:0] want_bud [3];
      logic       want_tog [3];
      want_bud = '{7'd8, 7'd8, 7'd2};
      want_tog = '{1'b1, 1'b0, 1'b1};
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b1, 16'd18, 1'b0, 1'b0, 7'd0);
      for (int i = 0; i < 3; i++) begin
         tok(4'd0, 1'b1, 1'b0, int'(want_bud[i]), 1'b1);
         total++; if (obs_bud !== want_bud[i] || obs_tog !== want_tog[i] || obs_hs !== hs_ack) begin
            bad++; $display("FAIL getdesc_pkt%0d got bud=%0d tog=%0d hs=%0d want bud=%0d tog=%0d hs=0",
                            i, obs_bud, obs_tog, obs_hs, want_bud[i], want_tog[i]); end
      end
      total++; if (obs_st !== ST_STATUS_OUT) begin bad++; $display("FAIL getdesc_stage got=%0d want=%0d", obs_st, ST_STATUS_OUT); end
      tok(4'd0, 1'b0, 1'b0, 0, 1'b1);
      total++; if (obs_tog !== 1'b1 || obs_done !== 1'b1 || obs_st !== ST_IDLE) begin
         bad++; $display("FAIL getdesc_status got tog=%0d done=%0d st=%0d want 1 1 0", obs_tog, obs_done, obs_st); end
   endtask

   task automatic test_retry();
      logic       t1;
      logic [6:0] b1;
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b1, 16'd20, 1'b0, 1'b0, 7'd0);
      tok(4'd0, 1'b1, 1'b0, 8, 1'b1);
      tok(4'd0, 1'b1, 1'b0, 8, 1'b0);
      t1 = obs_tog; b1 = obs_bud;
      total++; if (obs_tog !== exp_tog || obs_bud !== exp_bud) begin
         bad++; $display("FAIL retry_fail got tog=%0d bud=%0d want tog=%0d bud=%0d", obs_tog, obs_bud, exp_tog, exp_bud); end
      tok(4'd0, 1'b1, 1'b0, 8, 1'b1);
      total++; if (obs_tog !== t1 || obs_bud !== b1 || obs_tog !== 1'b0 || obs_bud !== 7'd8) begin
         bad++; $display("FAIL retry_repeat got tog=%0d bud=%0d want tog=0 bud=8", obs_tog, obs_bud); end
      tok(4'd0, 1'b1, 1'b0, 4, 1'b1);
      total++; if (obs_st !== exp_st || obs_bud !== 7'd4) begin
         bad++; $display("FAIL retry_last got st=%0d bud=%0d want st=%0d bud=4", obs_st, obs_bud, exp_st); end
      tok(4'd0, 1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic test_stall();
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b1, 16'd64, 1'b1, 1'b0, 7'd0);
      total++; if (obs_st !== ST_STALLED) begin bad++; $display("FAIL stall_stage got=%0d want=%0d", obs_st, ST_STALLED); end
      for (int i = 0; i < 3; i++) begin
         tok(4'd0, (i != 1), 1'b0, 0, 1'b1);
         total++; if (obs_hs !== hs_stall || obs_st !== ST_STALLED) begin
            bad++; $display("FAIL stall_tok%0d got hs=%0d st=%0d want hs=3 st=6", i, obs_hs, obs_st); end
      end
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      total++; if (obs_hs !== hs_ack || obs_tog !== 1'b0 || obs_st !== ST_DECODE) begin
         bad++; $display("FAIL stall_setup got hs=%0d tog=%0d st=%0d want 0 0 1", obs_hs, obs_tog, obs_st); end
      tok(4'd0, 1'b1, 1'b0, 0, 1'b1);
      total++; if (obs_hs !== hs_nak) begin bad++; $display("FAIL decode_nak got=%0d want=2", obs_hs); end
   endtask

   task automatic test_out_data();
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b0, 16'd10, 1'b0, 1'b0, 7'd0);
      tok(4'd0, 1'b1, 1'b0, 0, 1'b1);
      total++; if (obs_hs !== hs_nak) begin bad++; $display("FAIL out_in_nak got=%0d want=2", obs_hs); end
      tok(4'd0, 1'b0, 1'b0, 8, 1'b1);
      total++; if (obs_tog !== 1'b1 || obs_st !== ST_DATA_OUT) begin
         bad++; $display("FAIL out_pkt0 got tog=%0d st=%0d want 1 3", obs_tog, obs_st); end
      tok(4'd0, 1'b0, 1'b0, 2, 1'b1);
      total++; if (obs_tog !== 1'b0 || obs_st !== ST_STATUS_IN) begin
         bad++; $display("FAIL out_pkt1 got tog=%0d st=%0d want 0 4", obs_tog, obs_st); end
      tok(4'd0, 1'b1, 1'b0, 0, 1'b1);
      total++; if (obs_bud !== 7'd0 || obs_tog !== 1'b1 || obs_done !== 1'b1 || obs_st !== ST_IDLE) begin
         bad++; $display("FAIL out_zlp got bud=%0d tog=%0d done=%0d st=%0d want 0 1 1 0", obs_bud, obs_tog, obs_done, obs_st); end
   endtask

   task automatic test_non_ep0();
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b1, 16'd16, 1'b0, 1'b0, 7'd0);
      tok(4'd0, 1'b1, 1'b0, 8, 1'b1);
      tok(4'd5, 1'b1, 1'b0, 8, 1'b1);
      total++; if (obs_hs !== hs_stall || obs_st !== ST_DATA_IN) begin
         bad++; $display("FAIL nonep0 got hs=%0d st=%0d want 3 2", obs_hs, obs_st); end
      tok(4'd0, 1'b1, 1'b0, 8, 1'b0);
      total++; if (obs_tog !== 1'b0 || obs_bud !== 7'd8) begin
         bad++; $display("FAIL nonep0_after got tog=%0d bud=%0d want 0 8", obs_tog, obs_bud); end
      tok(4'd0, 1'b0, 1'b0, 0, 1'b1);
      total++; if (obs_hs !== hs_ack || obs_tog !== 1'b1 || obs_done !== 1'b1 || obs_st !== ST_IDLE) begin
         bad++; $display("FAIL early_status got hs=%0d tog=%0d done=%0d st=%0d want 0 1 1 0", obs_hs, obs_tog, obs_done, obs_st); end
   endtask

   task automatic test_abort();
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      send_req(1'b1, 16'd30, 1'b0, 1'b0, 7'd0);
      tok(4'd0, 1'b1, 1'b0, 8, 1'b1);
      tok(4'd0, 1'b0, 1'b1, 8, 1'b1);
      total++; if (obs_st !== ST_DECODE || obs_done !== 1'b0 || obs_hs !== hs_ack || obs_tog !== 1'b0) begin
         bad++; $display("FAIL abort got st=%0d done=%0d hs=%0d tog=%0d want 1 0 0 0", obs_st, obs_done, obs_hs, obs_tog); end
      @(negedge clk);
      usb_rst = 1'b1;
      @(negedge clk);
      usb_rst = 1'b0;
      model_reset();
      check_reset_values("usbrst");
   endtask

   task automatic test_random();
      logic [3:0] ep;
      logic       din, ok, sa, stl, rdir;
      int         n, len, guard;
      for (int k = 0; k < 25; k++) begin
         guard = 0;
         while (m_st != ST_DECODE && guard < 4) begin
            ok = ($urandom_range(0, 9) != 0);
            tok(4'd0, 1'b0, 1'b1, 8, ok);
            total++; if (obs_st !== exp_st || obs_hs !== hs_ack) begin
               bad++; $display("FAIL rnd_setup k=%0d got st=%0d hs=%0d want st=%0d hs=0", k, obs_st, obs_hs, exp_st); end
            guard++;
         end
         rdir = 1'($urandom_range(0, 1));
         len  = $urandom_range(0, 40);
         stl  = ($urandom_range(0, 5) == 0);
         sa   = ($urandom_range(0, 4) == 0);
         send_req(rdir, 16'(len), stl, sa, 7'($urandom_range(1, 127)));
         total++; if (obs_st !== exp_st) begin bad++; $display("FAIL rnd_req k=%0d got=%0d want=%0d", k, obs_st, exp_st); end
         guard = 0;
         while (m_st != ST_IDLE && guard < 14) begin
            ep = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ok = ($urandom_range(0, 4) != 0);
            n  = 0;
            case (m_st)
               ST_DATA_IN: begin
                  din = ($urandom_range(0, 5) != 0);
                  n   = din ? ((m_rem < 8) ? m_rem : 8) : 0;
               end
               ST_DATA_OUT: begin
                  din = ($urandom_range(0, 5) == 0);
                  n   = din ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : ((m_rem < 8) ? m_rem : 8));
               end
               ST_STATUS_IN:  din = ($urandom_range(0, 5) != 0);
               ST_STATUS_OUT: din = ($urandom_range(0, 5) == 0);
               default: begin
                  din = 1'($urandom_range(0, 1));
                  if (guard >= 2) guard = 14;
               end
            endcase
            tok(ep, din, 1'b0, n, ok);
            total++; if (obs_hs !== exp_hs) begin bad++; $display("FAIL rnd_hs k=%0d got=%0d want=%0d", k, obs_hs, exp_hs); end
            if (exp_hs == hs_ack) begin
               total++; if (obs_tog !== exp_tog || obs_bud !== exp_bud) begin
                  bad++; $display("FAIL rnd_data k=%0d got tog=%0d bud=%0d want tog=%0d bud=%0d", k, obs_tog, obs_bud, exp_tog, exp_bud); end
            end
            total++; if (obs_st !== exp_st || obs_done !== exp_done || obs_addr !== exp_addr) begin
               bad++; $display("FAIL rnd_end k=%0d got st=%0d done=%0d addr=%0h want st=%0d done=%0d addr=%0h",
                               k, obs_st, obs_done, obs_addr, exp_st, exp_done, exp_addr); end
            total++; if (obs_done2 !== 1'b0) begin bad++; $display("FAIL rnd_pulse k=%0d got=%0d want=0", k, obs_done2); end
            guard++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_set_address();
      test_get_descriptor();
      test_retry();
      test_stall();
      test_out_data();
      test_non_ep0();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
